mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Shares one memory port between instruction fetch and data access using a req/ack handshake.
//  Drives the datapath with the codebase control encodings for ALUOp, NPCOp, GPRSel and WDSel.
//  Halts on an illegal opcode or a memory timeout.
// PARAMETERS
//  WAIT_MAX   15   max cycles a memory request may wait for mem_ack before timeout (1..255)
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  rst        in   1  synchronous reset, active-high
//  run        in   1  leave IDLE and begin fetching; sampled only in IDLE
//  Op         in   6  opcode from instruction register
//  Funct      in   6  funct from instruction register
//  Zero       in   1  ALU zero flag, valid in EXEC
//  mem_ack    in   1  memory completed current request this cycle
//  mem_req    out  1  memory request; held until mem_ack
//  mem_we     out  1  request is a write (sw); valid with mem_req
//  IorD       out  1  0 = address from PC, 1 = address from ALUOut
//  IRWrite    out  1  load instruction register
//  PCWrite    out  1  load PC from NPC (per NPCOp)
//  RegWrite   out  1  register file write
//  ALUSrc     out  1  ALU B from extended immediate
//  ALU_A      out  1  ALU A from shamt (sll/srl)
//  EXTOp      out  1  sign extend immediate
//  ALUOp      out  4  ALU_NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, NOR=7, SLL=8, SRL=9, LUI=10, XOR=11
//  NPCOp      out  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR
//  GPRSel     out  2  00 rd, 01 rt, 10 r31
//  WDSel      out  2  00 ALU, 01 MEM, 10 PC
//  state      out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//  err        out  2  sticky: 00 none, 01 illegal op, 10 mem timeout
// BEHAVIOUR
//  Reset: state=IDLE; err=0; wait counter=0; every output is 0 (ALUOp=NOP, NPCOp=PLUS4). rst overrides all, including mid-handshake.
//  Outputs are combinational from state, Op/Funct/Zero and mem_ack. All outputs are 0 unless listed below.
//  IDLE: run=1 -> FETCH.
//  FETCH: mem_req=1, IorD=0. On mem_ack: IRWrite=1, PCWrite=1 (PLUS4), -> DECODE.
//  DECODE: register A/B load (datapath). Branches are resolved here:
//    - j:   PCWrite=1, NPCOp=JUMP -> FETCH
//    - jal: additionally RegWrite=1, GPRSel=10, WDSel=10
//    - unknown Op/Funct -> HALT, err=01
//    - all others -> EXEC
//  EXEC: ALUOp, ALUSrc, ALU_A, EXTOp are decoded as in the single-cycle control.
//    - beq/bne: ALUOp=SUB; PCWrite=(beq&Zero)|(bne&~Zero), NPCOp=BRANCH -> FETCH
//    - jr: PCWrite=1, NPCOp=JR -> FETCH
//    - jalr: as jr, plus RegWrite=1, GPRSel=00, WDSel=10
//    - lw/sw: ALUOp=ADD -> MEM
//    - all others -> WB
//  MEM: mem_req=1, IorD=1, mem_we=sw. On mem_ack: sw -> FETCH; lw -> WB.
//  WB: RegWrite=1. lw: GPRSel=01, WDSel=01. I-type ALU: GPRSel=01. R-type: GPRSel=00. -> FETCH.
//  Recognised ops: add addu sub subu and or nor xor slt sltu sll srl sllv srlv jr jalr addi andi ori slti lui lw sw beq bne j jal.
//  Handshake: once mem_req rises it stays high, with IorD/mem_we stable, until the cycle mem_ack=1. That cycle completes the request.
//    - mem_ack seen while mem_req=0 is ignored.
//  Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ack=0.
//    - When it reaches WAIT_MAX, the next cycle is HALT with err=10.
//    - An ack arriving on the cycle the counter equals WAIT_MAX still completes the request normally (ack wins).
//  HALT: all outputs 0. Stays until rst; run is ignored. err is held.
//  Writes (PCWrite/RegWrite/IRWrite) assert for exactly one cycle per instruction step. No write occurs in IDLE or HALT.
// TESTING
//  1. rst, run=1, fetch add (Funct=100000), ack immediately
//     -> states 1,2,3,5,1; ALUOp=0001 in EXEC; RegWrite=1 only in WB, GPRSel=00.
//  2. lw with mem_ack delayed 3 cycles in MEM
//     -> mem_req/IorD=1 held 4 cycles, mem_we=0; WB: WDSel=01, GPRSel=01. sw: mem_we=1, returns to FETCH with no RegWrite.
//  3. beq with Zero=1 and with Zero=0
//     -> PCWrite=1/NPCOp=01 vs PCWrite=0; both return to FETCH after EXEC. bne gives the inverse.
//  4. jal in DECODE
//     -> PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10, next state FETCH. jalr in EXEC -> NPCOp=11, WDSel=10.
//  5. WAIT_MAX=4, never ack in FETCH
//     -> HALT after 4 wait cycles, err=10. An ack on the 4th wait cycle -> normal DECODE, err=00.
//  6. Op=111111 -> HALT, err=01, no writes. Assert rst mid-MEM request -> next cycle IDLE, mem_req=0, err=00.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Multi-cycle control sequencer for the MIPS datapath.
//                Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB.
//                Instruction fetch and data access share one memory port
//                through a req/ack handshake. A bounded wait counter turns a
//                missing ack into a halt.
//
//  Ports
//    clk        in   clock, rising-edge
//    rst        in   synchronous reset, active-high
//    run        in   start fetching (sampled in IDLE only)
//    Op/Funct   in   opcode / funct from the instruction register
//    Zero       in   ALU zero flag (used in EXEC)
//    mem_ack    in   memory completed the current request this cycle
//    mem_req    out  memory request, held until mem_ack
//    mem_we     out  request is a write (sw)
//    IorD       out  0 = PC address, 1 = ALUOut address
//    IRWrite    out  load instruction register
//    PCWrite    out  load PC from NPC
//    RegWrite   out  register file write
//    ALUSrc     out  ALU B from extended immediate
//    ALU_A      out  ALU A from shamt
//    EXTOp      out  sign-extend immediate
//    ALUOp      out  ALU operation code
//    NPCOp      out  next-PC select
//    GPRSel     out  destination register select
//    WDSel      out  write-data select
//    state      out  current sequencer state
//    err        out  sticky error code (01 illegal op, 10 mem timeout)
//
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       ALU_A,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [2:0] state,
    output logic [1:0] err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] c_FN_SLL  = 6'b000000;
    localparam logic [5:0] c_FN_SRL  = 6'b000010;
    localparam logic [5:0] c_FN_SLLV = 6'b000100;
    localparam logic [5:0] c_FN_SRLV = 6'b000110;
    localparam logic [5:0] c_FN_JR   = 6'b001000;
    localparam logic [5:0] c_FN_JALR = 6'b001001;
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_XOR  = 6'b100110;
    localparam logic [5:0] c_FN_NOR  = 6'b100111;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SLTU = 6'b101011;

    // ALU operation codes
    localparam logic [3:0] c_ALU_NOP  = 4'd0;
    localparam logic [3:0] c_ALU_ADD  = 4'd1;
    localparam logic [3:0] c_ALU_SUB  = 4'd2;
    localparam logic [3:0] c_ALU_AND  = 4'd3;
    localparam logic [3:0] c_ALU_OR   = 4'd4;
    localparam logic [3:0] c_ALU_SLT  = 4'd5;
    localparam logic [3:0] c_ALU_SLTU = 4'd6;
    localparam logic [3:0] c_ALU_NOR  = 4'd7;
    localparam logic [3:0] c_ALU_SLL  = 4'd8;
    localparam logic [3:0] c_ALU_SRL  = 4'd9;
    localparam logic [3:0] c_ALU_LUI  = 4'd10;
    localparam logic [3:0] c_ALU_XOR  = 4'd11;

    // Next-PC, destination and write-data selects
    localparam logic [1:0] c_NPC_PLUS4  = 2'b00;
    localparam logic [1:0] c_NPC_BRANCH = 2'b01;
    localparam logic [1:0] c_NPC_JUMP   = 2'b10;
    localparam logic [1:0] c_NPC_JR     = 2'b11;
    localparam logic [1:0] c_GPR_RD     = 2'b00;
    localparam logic [1:0] c_GPR_RT     = 2'b01;
    localparam logic [1:0] c_GPR_R31    = 2'b10;
    localparam logic [1:0] c_WD_ALU     = 2'b00;
    localparam logic [1:0] c_WD_MEM     = 2'b01;
    localparam logic [1:0] c_WD_PC      = 2'b10;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] c_WAIT_MAX = 8'(WAIT_MAX);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [1:0] r_err;
    logic [7:0] r_wait;

    // ------------------------------------------------------------------
    // Instruction decode (pure function of Op/Funct)
    // ------------------------------------------------------------------
    logic       w_legal;
    logic       w_is_rtype;   // R-type ALU op, writes rd
    logic       w_is_itype;   // I-type ALU op, writes rt
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_bne;
    logic       w_is_j;
    logic       w_is_jal;
    logic       w_is_jr;
    logic       w_is_jalr;
    logic [3:0] w_alu_op;
    logic       w_alu_src;
    logic       w_alu_a;
    logic       w_ext_op;

    always_comb begin
        w_legal    = 1'b1;
        w_is_rtype = 1'b0;
        w_is_itype = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_is_beq   = 1'b0;
        w_is_bne   = 1'b0;
        w_is_j     = 1'b0;
        w_is_jal   = 1'b0;
        w_is_jr    = 1'b0;
        w_is_jalr  = 1'b0;
        w_alu_op   = c_ALU_NOP;
        w_alu_src  = 1'b0;
        w_alu_a    = 1'b0;
        w_ext_op   = 1'b0;

        case (Op)
            c_OP_RTYPE: begin
                case (Funct)
                    c_FN_ADD, c_FN_ADDU: begin w_is_rtype = 1'b1; w_alu_op = c_ALU_ADD;  end
                    c_FN_SUB, c_FN_SUBU: begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SUB;  end
                    c_FN_AND:            begin w_is_rtype = 1'b1; w_alu_op = c_ALU_AND;  end
                    c_FN_OR:             begin w_is_rtype = 1'b1; w_alu_op = c_ALU_OR;   end
                    c_FN_XOR:            begin w_is_rtype = 1'b1; w_alu_op = c_ALU_XOR;  end
                    c_FN_NOR:            begin w_is_rtype = 1'b1; w_alu_op = c_ALU_NOR;  end
                    c_FN_SLT:            begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SLT;  end
                    c_FN_SLTU:           begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SLTU; end
                    // Immediate shifts take A from shamt; variable shifts from rs
                    c_FN_SLL: begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SLL; w_alu_a = 1'b1; end
                    c_FN_SRL: begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SRL; w_alu_a = 1'b1; end
                    c_FN_SLLV:           begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SLL;  end
                    c_FN_SRLV:           begin w_is_rtype = 1'b1; w_alu_op = c_ALU_SRL;  end
                    c_FN_JR:             w_is_jr   = 1'b1;
                    c_FN_JALR:           w_is_jalr = 1'b1;
                    default:             w_legal   = 1'b0;
                endcase
            end
            c_OP_ADDI: begin w_is_itype = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 1'b1; w_ext_op = 1'b1; end
            c_OP_SLTI: begin w_is_itype = 1'b1; w_alu_op = c_ALU_SLT; w_alu_src = 1'b1; w_ext_op = 1'b1; end
            c_OP_ANDI: begin w_is_itype = 1'b1; w_alu_op = c_ALU_AND; w_alu_src = 1'b1; end
            c_OP_ORI:  begin w_is_itype = 1'b1; w_alu_op = c_ALU_OR;  w_alu_src = 1'b1; end
            c_OP_LUI:  begin w_is_itype = 1'b1; w_alu_op = c_ALU_LUI; w_alu_src = 1'b1; end
            c_OP_LW:   begin w_is_lw = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 1'b1; w_ext_op = 1'b1; end
            c_OP_SW:   begin w_is_sw = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 1'b1; w_ext_op = 1'b1; end
            c_OP_BEQ:  begin w_is_beq = 1'b1; w_alu_op = c_ALU_SUB; end
            c_OP_BNE:  begin w_is_bne = 1'b1; w_alu_op = c_ALU_SUB; end
            c_OP_J:    w_is_j   = 1'b1;
            c_OP_JAL:  w_is_jal = 1'b1;
            default:   w_legal  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic [2:0] w_next_state;
    logic [1:0] w_err_set;    // non-zero loads the sticky error register
    logic       w_wait_inc;   // request outstanding, not acked, not timed out
    logic       w_wait_hit;

    assign w_wait_hit = (r_wait == c_WAIT_MAX);

    always_comb begin
        w_next_state = r_state;
        w_err_set    = c_ERR_NONE;
        w_wait_inc   = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrc       = 1'b0;
        ALU_A        = 1'b0;
        EXTOp        = 1'b0;
        ALUOp        = c_ALU_NOP;
        NPCOp        = c_NPC_PLUS4;
        GPRSel       = c_GPR_RD;
        WDSel        = c_WD_ALU;

        case (r_state)
            c_ST_IDLE: begin
                if (run) begin
                    w_next_state = c_ST_FETCH;
                end
            end

            c_ST_FETCH: begin
                mem_req = 1'b1;
                // An ack wins even on the cycle the counter is at its limit
                if (mem_ack) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_next_state = c_ST_DECODE;
                end else if (w_wait_hit) begin
                    w_err_set    = c_ERR_TIMEOUT;
                    w_next_state = c_ST_HALT;
                end else begin
                    w_wait_inc   = 1'b1;
                end
            end

            c_ST_DECODE: begin
                if (!w_legal) begin
                    w_err_set    = c_ERR_ILLEGAL;
                    w_next_state = c_ST_HALT;
                end else if (w_is_j || w_is_jal) begin
                    PCWrite      = 1'b1;
                    NPCOp        = c_NPC_JUMP;
                    if (w_is_jal) begin
                        RegWrite = 1'b1;
                        GPRSel   = c_GPR_R31;
                        WDSel    = c_WD_PC;
                    end
                    w_next_state = c_ST_FETCH;
                end else begin
                    w_next_state = c_ST_EXEC;
                end
            end

            c_ST_EXEC: begin
                ALUOp  = w_alu_op;
                ALUSrc = w_alu_src;
                ALU_A  = w_alu_a;
                EXTOp  = w_ext_op;
                if (w_is_beq || w_is_bne) begin
                    PCWrite      = (w_is_beq & Zero) | (w_is_bne & ~Zero);
                    NPCOp        = c_NPC_BRANCH;
                    w_next_state = c_ST_FETCH;
                end else if (w_is_jr || w_is_jalr) begin
                    PCWrite      = 1'b1;
                    NPCOp        = c_NPC_JR;
                    if (w_is_jalr) begin
                        RegWrite = 1'b1;
                        GPRSel   = c_GPR_RD;
                        WDSel    = c_WD_PC;
                    end
                    w_next_state = c_ST_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next_state = c_ST_MEM;
                end else begin
                    w_next_state = c_ST_WB;
                end
            end

            c_ST_MEM: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                mem_we  = w_is_sw;
                if (mem_ack) begin
                    w_next_state = w_is_sw ? c_ST_FETCH : c_ST_WB;
                end else if (w_wait_hit) begin
                    w_err_set    = c_ERR_TIMEOUT;
                    w_next_state = c_ST_HALT;
                end else begin
                    w_wait_inc   = 1'b1;
                end
            end

            c_ST_WB: begin
                RegWrite = 1'b1;
                if (w_is_lw) begin
                    GPRSel = c_GPR_RT;
                    WDSel  = c_WD_MEM;
                end else if (w_is_itype) begin
                    GPRSel = c_GPR_RT;
                end else begin
                    GPRSel = c_GPR_RD;
                end
                w_next_state = c_ST_FETCH;
            end

            c_ST_HALT: begin
                w_next_state = c_ST_HALT;
            end

            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, sticky error and wait counter
    // The counter is zero whenever no request is waiting, so it is
    // already clear on every entry to FETCH or MEM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_err   <= c_ERR_NONE;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_err_set != c_ERR_NONE) begin
                r_err <= w_err_set;
            end
            if (w_wait_inc) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
        end
    end

    assign state = r_state;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl_fsm
//  Description : Self-checking bench for mc_ctrl_fsm. Each instruction's
//                expected cycle trace is built from the sequencing rules and
//                an instruction table, then compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam int c_WAIT = 4;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BEQ = 4, CL_BNE = 5,
                   CL_J = 6, CL_JAL = 7, CL_JR = 8, CL_JALR = 9;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] er;
        logic       req, we, iord, irw, pcw, rw, src, sha, ext;
        logic [3:0] alu;
        logic [1:0] npc, gpr, wds;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        logic [3:0] alu;
        logic       src, sha, ext;
    } ins_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         df, dm;
        int         exp_alu, exp_rw, exp_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, run, Zero, mem_ack;
    logic [5:0] Op, Funct;
    logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, ALUSrc, ALU_A, EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel, err;
    logic [2:0] state;

    mc_ctrl_fsm #(.WAIT_MAX(c_WAIT)) u_dut (
        .clk(clk), .rst(rst), .run(run), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .ALU_A(ALU_A), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel),
        .WDSel(WDSel), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    obs_t w_act;
    assign w_act = {state, err, mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite,
                    ALUSrc, ALU_A, EXTOp, ALUOp, NPCOp, GPRSel, WDSel};

    ins_t itab[27];
    vec_t vtab[17];
    int   n_checks = 0;
    int   n_errors = 0;
    int   g_alu, g_rw, g_cyc;

    task automatic set_ins(input int i, input int op, input int fn, input int cls,
                           input int alu, input int src, input int sha, input int ext);
        itab[i].op  = 6'(op);
        itab[i].fn  = 6'(fn);
        itab[i].cls = cls;
        itab[i].alu = 4'(alu);
        itab[i].src = 1'(src);
        itab[i].sha = 1'(sha);
        itab[i].ext = 1'(ext);
    endtask

    task automatic set_vec(input int i, input int op, input int fn, input int z, input int df,
                           input int dm, input int ea, input int er, input int ec);
        vtab[i].op = 6'(op); vtab[i].fn = 6'(fn); vtab[i].z = 1'(z);
        vtab[i].df = df; vtab[i].dm = dm;
        vtab[i].exp_alu = ea; vtab[i].exp_rw = er; vtab[i].exp_cyc = ec;
    endtask

    function automatic int find_ins(input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < 27; i++)
            if (itab[i].op == op && (op != 6'd0 || itab[i].fn == fn)) return i;
        return -1;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive ack just after the edge, compare at the falling edge
    task automatic cyc(input logic ack, input obs_t e, input string nm);
        mem_ack = ack;
        @(negedge clk);
        n_checks++;
        if (w_act !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, w_act, e, $time);
        end
        if (w_act.st == S_EXEC) g_alu = int'(w_act.alu);
        if (w_act.rw === 1'b1) g_rw++;
        g_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        obs_t e;
        e       = '0;
        rst     = 1'b1;
        run     = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, e, "reset_state");
        rst = 1'b0;
        run = 1'b0;
        cyc(rnd(), e, "idle_hold");
        run = 1'b1;
        cyc(rnd(), e, "idle_run");
    endtask

    task automatic halt_seq(input logic [1:0] code);
        obs_t e;
        e    = '0;
        e.st = S_HALT;
        e.er = code;
        run  = 1'b1;
        cyc(rnd(), e, "halt");
        cyc(rnd(), e, "halt_hold");
    endtask

    // Expected trace of one instruction, starting in FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int df, input int dm, output logic halted);
        int   idx;
        ins_t d;
        obs_t e;
        idx    = find_ins(op, fn);
        halted = 1'b0;
        Op = op; Funct = fn; Zero = z;
        g_alu = 0; g_rw = 0; g_cyc = 0;

        for (int k = 0; k < df; k++) begin
            e = '0; e.st = S_FETCH; e.req = 1'b1;
            cyc(1'b0, e, "fetch_wait");
            if (k == c_WAIT) begin halt_seq(2'b10); halted = 1'b1; return; end
        end
        e = '0; e.st = S_FETCH; e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(1'b1, e, "fetch_ack");

        e = '0; e.st = S_DEC;
        if (idx < 0) begin
            cyc(rnd(), e, "decode_illegal");
            halt_seq(2'b01);
            halted = 1'b1;
            return;
        end
        d = itab[idx];
        if (d.cls == CL_J || d.cls == CL_JAL) begin
            e.pcw = 1'b1; e.npc = 2'b10;
            if (d.cls == CL_JAL) begin e.rw = 1'b1; e.gpr = 2'b10; e.wds = 2'b10; end
            cyc(rnd(), e, "decode_jump");
            return;
        end
        cyc(rnd(), e, "decode");

        e = '0; e.st = S_EXEC; e.alu = d.alu; e.src = d.src; e.sha = d.sha; e.ext = d.ext;
        case (d.cls)
            CL_BEQ:  begin e.npc = 2'b01; e.pcw = z;  end
            CL_BNE:  begin e.npc = 2'b01; e.pcw = ~z; end
            CL_JR:   begin e.npc = 2'b11; e.pcw = 1'b1; end
            CL_JALR: begin e.npc = 2'b11; e.pcw = 1'b1; e.rw = 1'b1; e.wds = 2'b10; end
            default: ;
        endcase
        cyc(rnd(), e, "exec");
        if (d.cls == CL_BEQ || d.cls == CL_BNE || d.cls == CL_JR || d.cls == CL_JALR) return;

        if (d.cls == CL_LW || d.cls == CL_SW) begin
            e = '0; e.st = S_MEM; e.req = 1'b1; e.iord = 1'b1; e.we = (d.cls == CL_SW);
            for (int k = 0; k < dm; k++) begin
                cyc(1'b0, e, "mem_wait");
                if (k == c_WAIT) begin halt_seq(2'b10); halted = 1'b1; return; end
            end
            cyc(1'b1, e, "mem_ack");
            if (d.cls == CL_SW) return;
        end

        e = '0; e.st = S_WB; e.rw = 1'b1;
        e.gpr = (d.cls == CL_R) ? 2'b00 : 2'b01;
        e.wds = (d.cls == CL_LW) ? 2'b01 : 2'b00;
        cyc(rnd(), e, "wb");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        obs_t e;
        int   sel, df, dm;
        logic [5:0] op, fn;

        // op, fn, class, ALUOp, ALUSrc, ALU_A, EXTOp
        set_ins( 0, 'h00, 'h20, CL_R,  1, 0, 0, 0); set_ins( 1, 'h00, 'h21, CL_R,  1, 0, 0, 0);
        set_ins( 2, 'h00, 'h22, CL_R,  2, 0, 0, 0); set_ins( 3, 'h00, 'h23, CL_R,  2, 0, 0, 0);
        set_ins( 4, 'h00, 'h24, CL_R,  3, 0, 0, 0); set_ins( 5, 'h00, 'h25, CL_R,  4, 0, 0, 0);
        set_ins( 6, 'h00, 'h27, CL_R,  7, 0, 0, 0); set_ins( 7, 'h00, 'h26, CL_R, 11, 0, 0, 0);
        set_ins( 8, 'h00, 'h2A, CL_R,  5, 0, 0, 0); set_ins( 9, 'h00, 'h2B, CL_R,  6, 0, 0, 0);
        set_ins(10, 'h00, 'h00, CL_R,  8, 0, 1, 0); set_ins(11, 'h00, 'h02, CL_R,  9, 0, 1, 0);
        set_ins(12, 'h00, 'h04, CL_R,  8, 0, 0, 0); set_ins(13, 'h00, 'h06, CL_R,  9, 0, 0, 0);
        set_ins(14, 'h00, 'h08, CL_JR, 0, 0, 0, 0); set_ins(15, 'h00, 'h09, CL_JALR, 0, 0, 0, 0);
        set_ins(16, 'h08, 'h00, CL_I,  1, 1, 0, 1); set_ins(17, 'h0C, 'h00, CL_I,  3, 1, 0, 0);
        set_ins(18, 'h0D, 'h00, CL_I,  4, 1, 0, 0); set_ins(19, 'h0A, 'h00, CL_I,  5, 1, 0, 1);
        set_ins(20, 'h0F, 'h00, CL_I, 10, 1, 0, 0); set_ins(21, 'h23, 'h00, CL_LW, 1, 1, 0, 1);
        set_ins(22, 'h2B, 'h00, CL_SW, 1, 1, 0, 1); set_ins(23, 'h04, 'h00, CL_BEQ, 2, 0, 0, 0);
        set_ins(24, 'h05, 'h00, CL_BNE, 2, 0, 0, 0); set_ins(25, 'h02, 'h00, CL_J, 0, 0, 0, 0);
        set_ins(26, 'h03, 'h00, CL_JAL, 0, 0, 0, 0);

        // op, fn, Zero, fetch delay, mem delay, EXEC ALUOp, RegWrite pulses, cycles
        set_vec( 0, 'h00, 'h20, 0, 0, 0,  1, 1, 4);   // add
        set_vec( 1, 'h23, 'h00, 0, 0, 3,  1, 1, 8);   // lw, ack 3 cycles late
        set_vec( 2, 'h2B, 'h00, 0, 1, 1,  1, 0, 6);   // sw
        set_vec( 3, 'h04, 'h00, 1, 0, 0,  2, 0, 3);   // beq taken
        set_vec( 4, 'h04, 'h00, 0, 0, 0,  2, 0, 3);   // beq not taken
        set_vec( 5, 'h05, 'h00, 1, 0, 0,  2, 0, 3);   // bne not taken
        set_vec( 6, 'h05, 'h00, 0, 0, 0,  2, 0, 3);   // bne taken
        set_vec( 7, 'h03, 'h00, 0, 0, 0,  0, 1, 2);   // jal
        set_vec( 8, 'h02, 'h00, 0, 0, 0,  0, 0, 2);   // j
        set_vec( 9, 'h00, 'h09, 0, 0, 0,  0, 1, 3);   // jalr
        set_vec(10, 'h00, 'h08, 0, 0, 0,  0, 0, 3);   // jr
        set_vec(11, 'h0D, 'h00, 0, 0, 0,  4, 1, 4);   // ori
        set_vec(12, 'h00, 'h00, 0, 0, 0,  8, 1, 4);   // sll
        set_vec(13, 'h0F, 'h00, 0, 0, 0, 10, 1, 4);   // lui
        set_vec(14, 'h00, 'h26, 0, 2, 0, 11, 1, 6);   // xor, fetch waits 2
        set_vec(15, 'h00, 'h20, 0, 4, 0,  1, 1, 8);   // ack on final allowed fetch wait
        set_vec(16, 'h23, 'h00, 0, 0, 4,  1, 1, 9);   // ack on final allowed mem wait

        rst = 1'b1; run = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; mem_ack = 1'b0;
        do_start();

        for (int i = 0; i < 17; i++) begin
            run_instr(vtab[i].op, vtab[i].fn, vtab[i].z, vtab[i].df, vtab[i].dm, h);
            chk($sformatf("vec%0d_exec_aluop", i), g_alu, vtab[i].exp_alu);
            chk($sformatf("vec%0d_regwrites", i), g_rw, vtab[i].exp_rw);
            chk($sformatf("vec%0d_cycles", i), g_cyc, vtab[i].exp_cyc);
            if (h) do_start();
        end

        // Fetch never acked: one wait too many -> timeout halt
        run_instr(6'h00, 6'h20, 1'b0, c_WAIT + 1, 0, h);
        do_start();
        // Mem never acked
        run_instr(6'h2B, 6'h00, 1'b0, 0, c_WAIT + 1, h);
        do_start();
        // Illegal opcode, then illegal funct
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, h);
        chk("illegal_op_regwrites", g_rw, 0);
        do_start();
        run_instr(6'h00, 6'h3F, 1'b0, 1, 0, h);
        do_start();

        // Reset in the middle of a data request, with ack present
        Op = 6'h23; Funct = 6'h00;
        e = '0; e.st = S_FETCH; e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(1'b1, e, "mr_fetch");
        e = '0; e.st = S_DEC;
        cyc(1'b0, e, "mr_decode");
        e = '0; e.st = S_EXEC; e.alu = 4'd1; e.src = 1'b1; e.ext = 1'b1;
        cyc(1'b0, e, "mr_exec");
        e = '0; e.st = S_MEM; e.req = 1'b1; e.iord = 1'b1;
        cyc(1'b0, e, "mr_mem0");
        cyc(1'b0, e, "mr_mem1");
        do_start();

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 29);
            if (sel < 27) begin
                op = itab[sel].op; fn = itab[sel].fn;
            end else if (sel == 27) begin
                op = 6'h3F; fn = 6'($urandom);
            end else if (sel == 28) begin
                op = 6'h00; fn = 6'h3F;
            end else begin
                op = 6'h01; fn = 6'($urandom);
            end
            df = ($urandom_range(0, 15) == 0) ? c_WAIT + 1 : $urandom_range(0, c_WAIT);
            dm = ($urandom_range(0, 15) == 0) ? c_WAIT + 1 : $urandom_range(0, c_WAIT);
            run = rnd();
            run_instr(op, fn, rnd(), df, dm, h);
            if (h) do_start();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
